// File: rtl/lz77_encoder.sv
// LZ77 encoder: 9-symbol search buffer, 8-entry look-ahead, one
// (pos, len, literal) code per match round, terminated by TERM_CHAR.
module lz77_encoder #(
  parameter logic [7:0] TERM_CHAR = 8'h24,
  parameter int         SB_DEPTH  = 9,
  parameter int         LA_DEPTH  = 8,
  localparam int        POS_W     = $clog2(SB_DEPTH),
  localparam int        LEN_W     = $clog2(LA_DEPTH),
  localparam int        CNT_W     = $clog2(LA_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             valid,
  output logic             encode,
  output logic             finish,
  output logic [POS_W-1:0] code_pos,
  output logic [LEN_W-1:0] code_len,
  output logic [7:0]       char_nxt
);

  typedef enum logic [2:0] {S_FILL, S_MATCH, S_EMIT, S_SHIFT, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [LA_DEPTH-1:0][7:0]    la_q, la_d;     // la[0] is the oldest look-ahead char
  logic [SB_DEPTH-1:0][3:0]    sb_q, sb_d;     // sb[0] is the most recent symbol
  logic [CNT_W-1:0]            la_cnt_q, la_cnt_d;
  logic                        term_seen_q, term_seen_d;
  logic [POS_W-1:0]            pos_q, pos_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [7:0]                  chr_q, chr_d;
  logic                        finish_q, finish_d;
  logic [LEN_W-1:0]            shcnt_q, shcnt_d;

  logic [POS_W-1:0]            m_pos;
  logic [LEN_W-1:0]            m_len;
  int                          cap_i, run_i, best_i, bpos_i;
  logic [3:0]                  ref_sym;
  logic                        run_ok;

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      la_q        <= '0;
      sb_q        <= '0;
      la_cnt_q    <= '0;
      term_seen_q <= 1'b0;
      pos_q       <= '0;
      len_q       <= '0;
      chr_q       <= '0;
      finish_q    <= 1'b0;
      shcnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      la_q        <= la_d;
      sb_q        <= sb_d;
      la_cnt_q    <= la_cnt_d;
      term_seen_q <= term_seen_d;
      pos_q       <= pos_d;
      len_q       <= len_d;
      chr_q       <= chr_d;
      finish_q    <= finish_d;
      shcnt_q     <= shcnt_d;
    end
  end

  // Longest match over all distances; strict > keeps the nearest distance on ties.
  // The run is capped so the literal slot is always a real buffered char, and
  // it never swallows the terminator.
  always_comb begin
    best_i  = 0;
    bpos_i  = 0;
    run_i   = 0;
    run_ok  = 1'b0;
    ref_sym = '0;
    cap_i   = int'(la_cnt_q) - 1;
    if (cap_i > LA_DEPTH - 1) cap_i = LA_DEPTH - 1;
    for (int p = 0; p < SB_DEPTH; p++) begin
      run_i  = 0;
      run_ok = 1'b1;
      for (int k = 0; k < LA_DEPTH - 1; k++) begin
        // distance p+1 back from la[k]; reaching into the look-ahead allows overlap
        if (k >= p + 1) ref_sym = la_q[k-p-1][3:0];
        else            ref_sym = sb_q[p-k];
        if (run_ok && k < cap_i && la_q[k] != TERM_CHAR && la_q[k][3:0] == ref_sym)
          run_i = run_i + 1;
        else
          run_ok = 1'b0;
      end
      if (run_i > best_i) begin
        best_i = run_i;
        bpos_i = p;
      end
    end
    m_len = LEN_W'(best_i);
    m_pos = POS_W'(bpos_i);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (la_cnt_q == CNT_W'(LA_DEPTH) || term_seen_q) state_d = S_MATCH;
      S_MATCH: state_d = S_EMIT;
      S_EMIT:  state_d = S_SHIFT;
      S_SHIFT: if (shcnt_q == '0) begin
        if (finish_q)                                 state_d = S_DONE;
        else if (term_seen_q && la_cnt_q > CNT_W'(1)) state_d = S_MATCH;
        else                                          state_d = S_FILL;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_FILL;
    endcase
  end

  // Datapath next values: fill, capture match, arm shift count, slide windows
  always_comb begin
    la_d        = la_q;
    sb_d        = sb_q;
    la_cnt_d    = la_cnt_q;
    term_seen_d = term_seen_q;
    pos_d       = pos_q;
    len_d       = len_q;
    chr_d       = chr_q;
    finish_d    = finish_q;
    shcnt_d     = shcnt_q;
    case (state_q)
      S_FILL: if (in_valid && in_ready) begin
        la_d[la_cnt_q[LEN_W-1:0]] = chardata;
        la_cnt_d                  = la_cnt_q + CNT_W'(1);
        if (chardata == TERM_CHAR) term_seen_d = 1'b1;
      end
      S_MATCH: begin
        pos_d = m_pos;
        len_d = m_len;
        chr_d = la_q[m_len];
      end
      S_EMIT: begin
        shcnt_d = len_q;  // len copied symbols plus the literal
        if (chr_q == TERM_CHAR) finish_d = 1'b1;
      end
      S_SHIFT: begin
        sb_d     = {sb_q[SB_DEPTH-2:0], la_q[0][3:0]};
        la_d     = {8'h00, la_q[LA_DEPTH-1:1]};
        la_cnt_d = la_cnt_q - CNT_W'(1);
        if (shcnt_q != '0) shcnt_d = shcnt_q - LEN_W'(1);
      end
      default: ;
    endcase
  end

  // Outputs: handshake, code strobe, sticky finish (visible from the strobe cycle)
  always_comb begin
    in_ready = (state_q == S_FILL) && (la_cnt_q < CNT_W'(LA_DEPTH)) && !term_seen_q;
    valid    = (state_q == S_EMIT);
    finish   = finish_q || (valid && chr_q == TERM_CHAR);
  end

  assign encode   = 1'b1;
  assign code_pos = pos_q;
  assign code_len = len_q;
  assign char_nxt = chr_q;

endmodule

// File: tb/tb_lz77_encoder.sv
// Directed bench for lz77_encoder: hand-computed code sequences per stream.
module tb_lz77_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       in_valid;
  logic       in_ready, valid, encode, finish;
  logic [3:0] code_pos;
  logic [2:0] code_len;
  logic [7:0] char_nxt;

  typedef struct packed {
    logic [3:0] pos;
    logic [2:0] len;
    logic [7:0] ch;
    logic       fin;
  } code_t;

  code_t codes[$];
  int    tests = 0;
  int    fails = 0;

  lz77_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .chardata (chardata),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .valid    (valid),
    .encode   (encode),
    .finish   (finish),
    .code_pos (code_pos),
    .code_len (code_len),
    .char_nxt (char_nxt)
  );

  always #5 clk = ~clk;

  // capture every code strobe
  always @(negedge clk)
    if (!reset && valid) codes.push_back({code_pos, code_len, char_nxt, finish});

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    chardata = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    codes.delete();
  endtask

  task automatic feed(input string s, input bit gaps);
    int i   = 0;
    int cyc = 0;
    bit ph  = 1'b0;
    while (i < s.len() && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gaps && ph) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        chardata = s[i];
      end
      ph = ~ph;
      if (in_valid && in_ready) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (i != s.len()) begin
      fails++;
      $display("FAIL feed_timeout: accepted %0d chars, need %0d", i, s.len());
    end
  endtask

  task automatic wait_codes(input int n);
    int cyc = 0;
    while (codes.size() < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (codes.size() < n) begin
      fails++;
      $display("FAIL wait_codes: got %0d codes, need %0d", codes.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (valid !== 1'b0)    begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (finish !== 1'b0)   begin fails++; $display("FAIL reset_finish: got %b want 0", finish); end
    tests++; if (code_pos !== 4'd0) begin fails++; $display("FAIL reset_pos: got %0d want 0", code_pos); end
    tests++; if (code_len !== 3'd0) begin fails++; $display("FAIL reset_len: got %0d want 0", code_len); end
    tests++; if (char_nxt !== 8'h0) begin fails++; $display("FAIL reset_char: got %h want 00", char_nxt); end
    tests++; if (encode !== 1'b1)   begin fails++; $display("FAIL reset_encode: got %b want 1", encode); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_term_only();
    code_t e;
    code_t g;
    do_reset();
    feed("$", 1'b0);
    wait_codes(1);
    e = '{pos: 4'd0, len: 3'd0, ch: 8'h24, fin: 1'b1};
    g = (codes.size() > 0) ? codes[0] : 'x;
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL term_only_code: got pos=%0d len=%0d ch=%h fin=%b want pos=0 len=0 ch=24 fin=1",
               g.pos, g.len, g.ch, g.fin);
    end
    in_valid = 1'b1;
    chardata = 8'h31;
    repeat (20) @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL done_in_ready: got %b want 0", in_ready); end
    tests++; if (finish !== 1'b1)   begin fails++; $display("FAIL done_finish: got %b want 1", finish); end
    tests++; if (codes.size() != 1) begin fails++; $display("FAIL done_no_more_codes: got %0d codes want 1", codes.size()); end
    in_valid = 1'b0;
  endtask

  // run a stream and compare the code list against hand-derived values
  task automatic run_and_check(input string name, input string s, input bit gaps,
                               input int n, input code_t e0, input code_t e1, input code_t e2);
    code_t e[3];
    code_t g;
    e[0] = e0; e[1] = e1; e[2] = e2;
    do_reset();
    feed(s, gaps);
    if (gaps) begin
      tests++;
      if (codes.size() != 0) begin
        fails++;
        $display("FAIL %s_early_code: got %0d codes before match want 0", name, codes.size());
      end
    end
    wait_codes(n);
    repeat (20) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      g = (codes.size() > i) ? codes[i] : 'x;
      tests++;
      if (g !== e[i]) begin
        fails++;
        $display("FAIL %s_code%0d: got pos=%0d len=%0d ch=%h fin=%b want pos=%0d len=%0d ch=%h fin=%b",
                 name, i, g.pos, g.len, g.ch, g.fin, e[i].pos, e[i].len, e[i].ch, e[i].fin);
      end
    end
    tests++;
    if (codes.size() != n) begin
      fails++;
      $display("FAIL %s_count: got %0d codes want %0d", name, codes.size(), n);
    end
  endtask

  task automatic test_zero_run();
    run_and_check("zeros", "000000012$", 1'b0, 3,
                  '{4'd0, 3'd7, 8'h31, 1'b0}, '{4'd0, 3'd0, 8'h32, 1'b0}, '{4'd0, 3'd0, 8'h24, 1'b1});
  endtask

  task automatic test_overlap();
    run_and_check("r1212", "1212121$", 1'b0, 3,
                  '{4'd0, 3'd0, 8'h31, 1'b0}, '{4'd0, 3'd0, 8'h32, 1'b0}, '{4'd1, 3'd5, 8'h24, 1'b1});
  endtask

  task automatic test_gaps();
    run_and_check("gap1212", "1212121$", 1'b1, 3,
                  '{4'd0, 3'd0, 8'h31, 1'b0}, '{4'd0, 3'd0, 8'h32, 1'b0}, '{4'd1, 3'd5, 8'h24, 1'b1});
    run_and_check("gapzero", "00000001", 1'b1, 1,
                  '{4'd0, 3'd7, 8'h31, 1'b0}, '{4'd0, 3'd0, 8'h00, 1'b0}, '{4'd0, 3'd0, 8'h00, 1'b0});
  endtask

  task automatic test_term_cap();
    run_and_check("cap11", "11$", 1'b0, 2,
                  '{4'd0, 3'd0, 8'h31, 1'b0}, '{4'd0, 3'd1, 8'h24, 1'b1}, '{4'd0, 3'd0, 8'h00, 1'b0});
  endtask

  task automatic test_reset_in_shift();
    code_t g;
    do_reset();
    feed("00000001", 1'b0);
    wait_codes(1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    codes.delete();
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rs_in_ready: got %b want 1", in_ready); end
    tests++; if (valid !== 1'b0)    begin fails++; $display("FAIL rs_valid: got %b want 0", valid); end
    tests++; if (code_len !== 3'd0) begin fails++; $display("FAIL rs_len: got %0d want 0", code_len); end
    tests++; if (char_nxt !== 8'h0) begin fails++; $display("FAIL rs_char: got %h want 00", char_nxt); end
    repeat (20) @(negedge clk);
    tests++; if (codes.size() != 0) begin fails++; $display("FAIL rs_quiet: got %0d codes want 0", codes.size()); end
    feed("$", 1'b0);
    wait_codes(1);
    g = (codes.size() > 0) ? codes[0] : 'x;
    tests++;
    if (g !== code_t'{4'd0, 3'd0, 8'h24, 1'b1}) begin
      fails++;
      $display("FAIL rs_term_code: got pos=%0d len=%0d ch=%h fin=%b want pos=0 len=0 ch=24 fin=1",
               g.pos, g.len, g.ch, g.fin);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    chardata = 8'h00;
    test_reset();
    test_term_only();
    test_zero_run();
    test_overlap();
    test_gaps();
    test_term_cap();
    test_reset_in_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
